// File: rtl/acc_credit_ctrl.sv
// rtl/acc_credit_ctrl.sv - per-target and total credit gating of an offload request stream, with drain sequencing
// Optional watchdog: define ACC_CREDIT_TIMEOUT_EN.
module acc_credit_ctrl #(
    parameter int unsigned NumTgt         = 4,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned TotalMax       = 8,
    parameter int unsigned TgtWidth       = (NumTgt > 1) ? $clog2(NumTgt) : 1,
    parameter int unsigned TimeoutCycles  = 1024
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                q_valid_i,
    output logic                q_ready_o,
    input  logic [TgtWidth-1:0] q_tgt_i,
    output logic                q_valid_o,
    input  logic                q_ready_i,
    input  logic                p_valid_i,
    input  logic                p_ready_i,
    input  logic [TgtWidth-1:0] p_tgt_i,
    input  logic                flush_i,
    output logic                drained_o,
    output logic                busy_o,
    output logic                decode_err_o,
    output logic                protocol_err_o,
    output logic                timeout_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned TotW = $clog2(TotalMax + 1);

    if (NumTgt < 2 || MaxOutstanding < 1 || TotalMax < 1 || TimeoutCycles < 1) begin : g_param_check
        $error("acc_credit_ctrl: illegal parameter value");
    end

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q [NumTgt];
    logic [CntW-1:0]     cnt_d [NumTgt];
    logic [TotW-1:0]     total_q, total_d;
    logic                drained_q, drained_d;
    logic                decode_err_q, decode_err_d;
    logic                protocol_err_q, protocol_err_d;

    logic                q_inrange, p_inrange;
    logic [TgtWidth-1:0] q_idx, p_idx;
    logic                allow, issue, retire, retire_ok;

    // Admission looks only at registered counts; a credit returned this cycle is usable next cycle.
    always_comb begin
        q_inrange = 32'(q_tgt_i) < NumTgt;
        p_inrange = 32'(p_tgt_i) < NumTgt;
        q_idx     = q_inrange ? q_tgt_i : '0;
        p_idx     = p_inrange ? p_tgt_i : '0;
        allow     = (state_q == RUN) && q_inrange
                    && (cnt_q[q_idx] < CntW'(MaxOutstanding))
                    && (total_q < TotW'(TotalMax));
        q_valid_o = q_valid_i & allow;
        q_ready_o = ((state_q == RUN) && !q_inrange) ? 1'b1 : (q_ready_i & allow);
        issue     = q_valid_o & q_ready_i;
        retire    = p_valid_i & p_ready_i;
        retire_ok = retire & p_inrange & (cnt_q[p_idx] != '0);
    end

    always_comb begin
        for (int t = 0; t < NumTgt; t++) begin
            cnt_d[t] = cnt_q[t];
            if (issue && (q_idx == TgtWidth'(t))) begin
                cnt_d[t] = cnt_d[t] + CntW'(1);
            end
            if (retire_ok && (p_idx == TgtWidth'(t))) begin
                cnt_d[t] = cnt_d[t] - CntW'(1);
            end
        end
        total_d = total_q;
        if (issue) begin
            total_d = total_d + TotW'(1);
        end
        if (retire_ok) begin
            total_d = total_d - TotW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (flush_i) state_d = DRAIN;
            DRAIN:   if (total_q == '0) state_d = DONE;
            DONE:    state_d = RUN;
            default: state_d = RUN;
        endcase
        drained_d      = (state_d == DONE);
        decode_err_d   = (state_q == RUN) & q_valid_i & ~q_inrange;
        protocol_err_d = protocol_err_q | (retire & ~retire_ok);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= RUN;
            total_q        <= '0;
            drained_q      <= 1'b0;
            decode_err_q   <= 1'b0;
            protocol_err_q <= 1'b0;
            for (int t = 0; t < NumTgt; t++) begin
                cnt_q[t] <= '0;
            end
        end else begin
            state_q        <= state_d;
            total_q        <= total_d;
            drained_q      <= drained_d;
            decode_err_q   <= decode_err_d;
            protocol_err_q <= protocol_err_d;
            for (int t = 0; t < NumTgt; t++) begin
                cnt_q[t] <= cnt_d[t];
            end
        end
    end

    assign drained_o      = drained_q;
    assign decode_err_o   = decode_err_q;
    assign protocol_err_o = protocol_err_q;
    assign busy_o         = (total_q != '0);

`ifdef ACC_CREDIT_TIMEOUT_EN
    logic [31:0] wd_q, wd_d;
    logic        timeout_q, timeout_d;

    // Any response, even an erroneous one, counts as forward progress.
    always_comb begin
        if (retire || (total_q == '0)) begin
            wd_d = '0;
        end else if (wd_q != 32'(TimeoutCycles)) begin
            wd_d = wd_q + 32'd1;
        end else begin
            wd_d = wd_q;
        end
        timeout_d = timeout_q | (wd_d == 32'(TimeoutCycles));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_acc_credit_ctrl.sv
// tb/tb_acc_credit_ctrl.sv - scoreboard bench for acc_credit_ctrl
module tb_acc_credit_ctrl;

`ifdef ACC_CREDIT_TIMEOUT_EN
    localparam bit TmoEn = 1'b1;
`else
    localparam bit TmoEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       q_valid_i = 1'b0, q_ready_i = 1'b0;
    logic       p_valid_i = 1'b0, p_ready_i = 1'b0;
    logic       flush_i = 1'b0;
    logic [2:0] q_tgt_i = '0, p_tgt_i = '0;
    logic       q_ready_o, q_valid_o, drained_o, busy_o;
    logic       decode_err_o, protocol_err_o, timeout_o;

    acc_credit_ctrl #(
        .NumTgt        (5),
        .MaxOutstanding(4),
        .TotalMax      (8),
        .TimeoutCycles (16)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .q_valid_i     (q_valid_i),
        .q_ready_o     (q_ready_o),
        .q_tgt_i       (q_tgt_i),
        .q_valid_o     (q_valid_o),
        .q_ready_i     (q_ready_i),
        .p_valid_i     (p_valid_i),
        .p_ready_i     (p_ready_i),
        .p_tgt_i       (p_tgt_i),
        .flush_i       (flush_i),
        .drained_o     (drained_o),
        .busy_o        (busy_o),
        .decode_err_o  (decode_err_o),
        .protocol_err_o(protocol_err_o),
        .timeout_o     (timeout_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ev = {q_valid_o, q_ready_o, busy_o, drained_o, decode_err_o, protocol_err_o, timeout_o}
    typedef struct {
        int         cyc;
        string      name;
        logic [6:0] ev;
        int         tot;
        int         ct;
        int         cv;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic step(input logic qv, input logic [2:0] qt, input logic qr,
                        input logic pv, input logic pr, input logic [2:0] pt,
                        input logic fl, input logic [6:0] ev,
                        input int tot, input int ct, input int cv, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        q_valid_i = qv; q_tgt_i = qt; q_ready_i = qr;
        p_valid_i = pv; p_ready_i = pr; p_tgt_i = pt;
        flush_i   = fl;
        e.cyc = cyc; e.name = nm; e.ev = ev; e.tot = tot; e.ct = ct; e.cv = cv;
        sb.push_back(e);
    endtask

    task automatic idle(input logic [6:0] ev, input int tot, input string nm);
        step(0, 0, 0, 0, 0, 0, 0, ev, tot, -1, 0, nm);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #1;
        rst_i = 1'b1;
        q_valid_i = 0; q_ready_i = 0; p_valid_i = 0; p_ready_i = 0; flush_i = 0;
        @(negedge clk);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin : monitor
        exp_t       e;
        logic [6:0] act;
        forever begin
            @(negedge clk);
            while (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e   = sb.pop_front();
                act = {q_valid_o, q_ready_o, busy_o, drained_o,
                       decode_err_o, protocol_err_o, timeout_o};
                n_cmp++;
                if (e.cyc != cyc || act !== e.ev) begin
                    n_err++;
                    $display("FAIL %s cyc=%0d/%0d outputs got=%b exp=%b", e.name, cyc, e.cyc, act, e.ev);
                end
                if (e.tot >= 0) begin
                    n_cmp++;
                    if (int'(dut.total_q) != e.tot) begin
                        n_err++;
                        $display("FAIL %s total got=%0d exp=%0d", e.name, dut.total_q, e.tot);
                    end
                end
                if (e.ct >= 0) begin
                    n_cmp++;
                    if (int'(dut.cnt_q[e.ct]) != e.cv) begin
                        n_err++;
                        $display("FAIL %s cnt[%0d] got=%0d exp=%0d", e.name, e.ct, dut.cnt_q[e.ct], e.cv);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        repeat (2) @(posedge clk);
        step(0, 0, 0, 0, 0, 0, 0, 7'b0000000, 0, 1, 0, "reset");
        rst_i = 1'b0;

        // credit exhaustion on target 1
        step(1, 1, 1, 0, 0, 0, 0, 7'b1100000, 0, -1, 0, "exh_issue0");
        for (int i = 1; i < 4; i++) step(1, 1, 1, 0, 0, 0, 0, 7'b1110000, i, 1, i, "exh_issue");
        step(1, 1, 1, 0, 0, 0, 0, 7'b0010000, 4, 1, 4, "exh_stall5");
        step(1, 1, 1, 1, 1, 1, 0, 7'b0010000, 4, 1, 4, "exh_no_bypass");
        step(1, 1, 1, 0, 0, 0, 0, 7'b1110000, 3, 1, 3, "exh_issue5");
        step(0, 1, 1, 0, 0, 0, 0, 7'b0010000, 4, 1, 4, "exh_full_ready");
        step(0, 0, 0, 1, 0, 1, 0, 7'b0010000, 4, 1, 4, "p_ready_low");
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 1, 0, 7'b0010000, 4 - i, 1, 4 - i, "ret_t1");
        step(0, 0, 0, 0, 0, 0, 0, 7'b0000000, 0, 1, 0, "ret_t1_done");

        // total limit, then simultaneous issue/retire
        for (int i = 0; i < 4; i++)
            step(1, 0, 1, 0, 0, 0, 0, (i == 0) ? 7'b1100000 : 7'b1110000, i, 0, i, "tot_issue_t0");
        for (int i = 0; i < 4; i++) step(1, 2, 1, 0, 0, 0, 0, 7'b1110000, 4 + i, 2, i, "tot_issue_t2");
        step(1, 3, 1, 0, 0, 0, 0, 7'b0010000, 8, 3, 0, "tot_limit_t3");
        step(0, 0, 0, 1, 1, 2, 0, 7'b0010000, 8, 2, 4, "ret_t2");
        step(1, 2, 1, 1, 1, 2, 0, 7'b1110000, 7, 2, 3, "same_tgt_io");
        step(1, 1, 1, 1, 1, 0, 0, 7'b1110000, 7, 2, 3, "diff_tgt_io");
        step(0, 0, 0, 0, 0, 0, 0, 7'b0010000, 7, 0, 3, "diff_cnt0");
        step(0, 0, 0, 0, 0, 0, 0, 7'b0010000, 7, 1, 1, "diff_cnt1");

        // drain with 3 outstanding on target 2
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 0, 0, 7'b0010000, 7 - i, 0, 3 - i, "ret_t0");
        step(0, 0, 0, 1, 1, 1, 0, 7'b0010000, 4, 1, 1, "ret_t1b");
        step(0, 0, 0, 0, 0, 0, 1, 7'b0010000, 3, 2, 3, "flush");
        step(1, 0, 1, 0, 0, 0, 1, 7'b0010000, 3, -1, 0, "drain_stall");
        for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 1, 2, 0, 7'b0010000, 3 - i, 2, 3 - i, "drain_ret");
        step(1, 0, 1, 0, 0, 0, 0, 7'b0000000, 0, -1, 0, "drain_empty");
        step(1, 0, 1, 0, 0, 0, 0, 7'b0001000, 0, -1, 0, "drained");
        step(1, 0, 1, 0, 0, 0, 0, 7'b1100000, 0, -1, 0, "run_resume");
        step(0, 0, 0, 0, 0, 0, 0, 7'b0010000, 1, 0, 1, "resume_cnt");
        step(0, 0, 0, 1, 1, 0, 0, 7'b0010000, 1, -1, 0, "ret_resume");
        idle(7'b0000000, 0, "idle0");
        step(0, 0, 0, 0, 0, 0, 1, 7'b0000000, 0, -1, 0, "flush_n");
        idle(7'b0000000, 0, "flush_n1");
        idle(7'b0001000, 0, "flush_n2");
        idle(7'b0000000, 0, "flush_n3");

        // decode errors
        step(1, 5, 0, 0, 0, 0, 0, 7'b0100000, 0, -1, 0, "dec_consume");
        idle(7'b0000100, 0, "dec_pulse");
        idle(7'b0000000, 0, "dec_clear");
        step(0, 0, 0, 0, 0, 0, 1, 7'b0000000, 0, -1, 0, "flush2");
        step(1, 5, 1, 0, 0, 0, 0, 7'b0000000, 0, -1, 0, "dec_held_drain");
        step(1, 5, 1, 0, 0, 0, 0, 7'b0001000, 0, -1, 0, "dec_held_done");
        idle(7'b0000000, 0, "dec_none");

        // protocol errors and mid-traffic reset
        step(0, 0, 0, 1, 1, 3, 0, 7'b0000000, 0, 3, 0, "prot_ret");
        step(1, 3, 1, 0, 0, 0, 0, 7'b1100010, 0, -1, 0, "prot_set");
        step(0, 0, 0, 0, 0, 0, 0, 7'b0010010, 1, 3, 1, "prot_sticky");
        step(0, 0, 0, 1, 1, 6, 0, 7'b0010010, 1, 3, 1, "prot_oor_ret");
        step(1, 0, 1, 0, 0, 0, 0, 7'b1110010, 1, 3, 1, "mid_traffic");
        @(negedge clk);
        #1;
        rst_i = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, 7'b0000000, 0, 3, 0, "rst_mid");
        @(negedge clk);
        #1;
        rst_i = 1'b0;
        step(0, 0, 0, 1, 1, 0, 0, 7'b0000000, 0, 0, 0, "late_resp");
        idle(7'b0000010, 0, "late_prot");

        // watchdog: no response
        pulse_reset();
        step(1, 0, 1, 0, 0, 0, 0, 7'b1100000, 0, -1, 0, "wd_issue");
        for (int i = 1; i <= 16; i++) idle(7'b0010000, 1, "wd_count");
        idle({6'b001000, TmoEn}, 1, "wd_fire");
        step(0, 0, 0, 1, 1, 0, 0, {6'b001000, TmoEn}, 1, -1, 0, "wd_sticky");
        idle({6'b000000, TmoEn}, 0, "wd_sticky_idle");

        // watchdog: response at cycle 10
        pulse_reset();
        step(1, 0, 1, 0, 0, 0, 0, 7'b1100000, 0, -1, 0, "wd2_issue");
        for (int i = 1; i < 10; i++) idle(7'b0010000, 1, "wd2_wait");
        step(0, 0, 0, 1, 1, 0, 0, 7'b0010000, 1, -1, 0, "wd2_retire");
        for (int i = 0; i < 15; i++) idle(7'b0000000, 0, "wd2_quiet");

        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
